// File: rtl/axi_fill_pkg.sv
// Shared types and constants for the AXI pattern-fill master.
package axi_fill_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_FIN
    } fill_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam int unsigned BOUNDARY_4K = 4096;

    // Beats that fit between addr and the next 4 KB boundary.
    function automatic logic [31:0] beats_to_4k(input logic [11:0] addr_lo,
                                                input int unsigned bytes_per_beat);
        return (BOUNDARY_4K - 32'(addr_lo)) / bytes_per_beat;
    endfunction

endpackage

// File: rtl/axi_fill_burst_calc.sv
// Burst sizing and next-address arithmetic for the pattern-fill master.
// first_beats sizes a burst at cur_addr; next_* describe the state after the
// current burst of cur_beats completes, so the follow-on burst can be sized
// in the same cycle the response is accepted.
module axi_fill_burst_calc
    import axi_fill_pkg::*;
#(
    parameter int unsigned ADDR_W    = 44,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic [ADDR_W-1:0] cur_addr,
    input  logic [31:0]       rem_beats,
    input  logic [8:0]        cur_beats,
    output logic [8:0]        first_beats,
    output logic [ADDR_W-1:0] next_addr,
    output logic [31:0]       next_rem,
    output logic [8:0]        next_beats
);

    localparam int unsigned BPB   = DATA_W / 8;
    localparam int unsigned LOG2B = $clog2(BPB);

    function automatic logic [8:0] size_burst(input logic [ADDR_W-1:0] addr,
                                              input logic [31:0]       rem);
        logic [31:0] b;
        logic [31:0] lim;
        b = rem;
        if (b > 32'(MAX_BEATS)) b = 32'(MAX_BEATS);
        lim = beats_to_4k(addr[11:0], BPB);
        if (b > lim) b = lim;
        return b[8:0];
    endfunction

    assign first_beats = size_burst(cur_addr, rem_beats);
    assign next_addr   = cur_addr + (ADDR_W'(cur_beats) << LOG2B);
    assign next_rem    = rem_beats - 32'(cur_beats);
    assign next_beats  = size_burst(next_addr, next_rem);

endmodule

// File: rtl/axi_pattern_fill_master.sv
// AXI4 write master that fills a memory region with a constant pattern,
// then pulses done and raises a level irq.
// Optional: define PATTERN_FILL_ADDR_DATA_EN to make each 32-bit lane of a
// beat carry its own byte address instead of PATTERN.
module axi_pattern_fill_master
    import axi_fill_pkg::*;
#(
    parameter int unsigned  ADDR_W    = 44,
    parameter int unsigned  DATA_W    = 128,
    parameter int unsigned  MAX_BEATS = 4,
    parameter logic [127:0] PATTERN   = 128'hDEADBEAF12345678AABBCCDD11223344
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [31:0]         cfg_bytes,
    output logic                busy,
    output logic                done,
    output logic                irq,
    input  logic                irq_clr,
    output logic                error,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready
);

    localparam int unsigned BPB   = DATA_W / 8;
    localparam int unsigned LOG2B = $clog2(BPB);

    fill_state_t       state;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       rem_beats;
    logic [8:0]        beats_q;
    logic [7:0]        beat_cnt;
    logic              cfg_bad;

    logic [8:0]        first_beats;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       next_rem;
    logic [8:0]        next_beats;

    axi_fill_burst_calc #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS)
    ) u_calc (
        .cur_addr    (cur_addr),
        .rem_beats   (rem_beats),
        .cur_beats   (beats_q),
        .first_beats (first_beats),
        .next_addr   (next_addr),
        .next_rem    (next_rem),
        .next_beats  (next_beats)
    );

    assign m_axi_awsize  = 3'(LOG2B);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wstrb   = '1;

`ifdef PATTERN_FILL_ADDR_DATA_EN
    logic [ADDR_W-1:0] w_addr;

    function automatic logic [DATA_W-1:0] lane_addr_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        for (int unsigned k = 0; k < DATA_W / 32; k++)
            r[k*32 +: 32] = a[31:0] + 32'(k * 4);
        return r;
    endfunction

    // Track the byte address of the beat currently on the W channel.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_addr <= '0;
        end else if (state == S_ADDR && m_axi_awready) begin
            w_addr <= cur_addr;
        end else if (m_axi_wvalid && m_axi_wready) begin
            w_addr <= w_addr + ADDR_W'(BPB);
        end
    end

    assign m_axi_wdata = lane_addr_word(w_addr);
`else
    function automatic logic [DATA_W-1:0] replicate_pattern();
        logic [DATA_W-1:0] r;
        for (int unsigned i = 0; i < DATA_W; i++)
            r[i] = PATTERN[i % 128];
        return r;
    endfunction

    localparam logic [DATA_W-1:0] PAT_WORD = replicate_pattern();

    assign m_axi_wdata = PAT_WORD;
`endif

    // Fill sequencer: config check, then AW / W / B per burst, one burst in flight.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= S_IDLE;
            cur_addr      <= '0;
            rem_beats     <= '0;
            beats_q       <= '0;
            beat_cnt      <= '0;
            cfg_bad       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            irq           <= 1'b0;
            error         <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wlast   <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (irq_clr) irq <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_addr  <= cfg_addr;
                        rem_beats <= cfg_bytes >> LOG2B;
                        cfg_bad   <= (cfg_addr[LOG2B-1:0] != '0) || (cfg_bytes == '0) ||
                                     (cfg_bytes[LOG2B-1:0] != '0);
                        error     <= 1'b0;
                        irq       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cfg_bad) begin
                        error <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        m_axi_awaddr  <= cur_addr;
                        m_axi_awlen   <= 8'(first_beats - 9'd1);
                        beats_q       <= first_beats;
                        m_axi_awvalid <= 1'b1;
                        state         <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b1;
                        m_axi_wlast   <= (m_axi_awlen == 8'd0);
                        beat_cnt      <= '0;
                        state         <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (m_axi_wready) begin
                        if (m_axi_wlast) begin
                            m_axi_wvalid <= 1'b0;
                            m_axi_wlast  <= 1'b0;
                            m_axi_bready <= 1'b1;
                            state        <= S_RESP;
                        end else begin
                            beat_cnt    <= beat_cnt + 8'd1;
                            m_axi_wlast <= ((beat_cnt + 8'd1) == m_axi_awlen);
                        end
                    end
                end
                S_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != AXI_RESP_OKAY) begin
                            error <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            cur_addr  <= next_addr;
                            rem_beats <= next_rem;
                            if (next_rem != '0) begin
                                m_axi_awaddr  <= next_addr;
                                m_axi_awlen   <= 8'(next_beats - 9'd1);
                                beats_q       <= next_beats;
                                m_axi_awvalid <= 1'b1;
                                state         <= S_ADDR;
                            end else begin
                                state <= S_FIN;
                            end
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    irq   <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
